// File: rtl/bus_tenure_arbiter_if.sv
// Request/grant handshake bundle between four bus masters and the tenure arbiter.
// Signals ending in '_' are active-low.
interface bus_tenure_arbiter_if;
    logic       m0_req_;
    logic       m1_req_;
    logic       m2_req_;
    logic       m3_req_;
    logic       m0_grnt_;
    logic       m1_grnt_;
    logic       m2_grnt_;
    logic       m3_grnt_;
    logic       bus_rdy_;
    logic [1:0] owner;
    logic       turn;
    logic       tenure_exp;

    modport slave (
        input  m0_req_, m1_req_, m2_req_, m3_req_, bus_rdy_,
        output m0_grnt_, m1_grnt_, m2_grnt_, m3_grnt_, owner, turn, tenure_exp
    );

    modport master (
        output m0_req_, m1_req_, m2_req_, m3_req_, bus_rdy_,
        input  m0_grnt_, m1_grnt_, m2_grnt_, m3_grnt_, owner, turn, tenure_exp
    );
endinterface

// File: rtl/bus_tenure_arbiter.sv
// Four-master rotating-priority bus arbiter with a one-cycle dead TURN between owners.
// Define BUS_ARB_TENURE_EN to enable the tenure limit (forced handoff after TENURE contended cycles).
//
// state | meaning
// GRANT | grant of owner asserted; counting contended cycles
// TURN  | all grants high for one cycle; owner already holds the next master
module bus_tenure_arbiter #(
    parameter int unsigned TENURE = 16
) (
    input logic clk,
    input logic reset,
    bus_tenure_arbiter_if.slave bus
);
    typedef enum logic {GRANT = 1'b0, TURN = 1'b1} state_t;

    state_t     state;
    logic [1:0] owner_q;
    logic [1:0] next_owner;
    logic [3:0] req;
    logic [3:0] others;
    logic [3:0] grant_n;
    logic       handoff;

    assign req    = ~{bus.m3_req_, bus.m2_req_, bus.m1_req_, bus.m0_req_};
    assign others = req & ~(4'b0001 << owner_q);

    // Rotating priority: the nearest requester after the owner wins.
    always_comb begin
        logic [1:0] idx;
        next_owner = owner_q;
        for (int k = 3; k >= 1; k--) begin
            idx = owner_q + 2'(k);
            if (req[idx]) next_owner = idx;
        end
    end

`ifdef BUS_ARB_TENURE_EN
    logic [7:0] cnt;
    logic       expired;

    assign expired = (cnt == 8'(TENURE));

    always_comb begin
        handoff = 1'b0;
        if (state == GRANT && others != 4'b0000) begin
            if (!req[owner_q]) handoff = 1'b1;
            else if (expired && !bus.bus_rdy_) handoff = 1'b1;
        end
    end

    // Counter saturates at TENURE; an expired owner waits for bus_rdy_ before yielding.
    always_ff @(posedge clk) begin
        if (!reset || handoff || others == 4'b0000 || state == TURN) cnt <= 8'd0;
        else if (!expired) cnt <= cnt + 8'd1;
    end

    assign bus.tenure_exp = expired;
`else
    logic unused_bus_rdy;
    assign unused_bus_rdy = bus.bus_rdy_;

    always_comb begin
        handoff = 1'b0;
        if (state == GRANT && others != 4'b0000 && !req[owner_q]) handoff = 1'b1;
    end

    assign bus.tenure_exp = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= GRANT;
            owner_q <= 2'd0;
        end else begin
            case (state)
                GRANT: begin
                    if (handoff) begin
                        owner_q <= next_owner;
                        state   <= TURN;
                    end
                end
                TURN:    state <= GRANT;
                default: state <= GRANT;
            endcase
        end
    end

    always_comb begin
        grant_n = 4'b1111;
        if (state == GRANT) grant_n[owner_q] = 1'b0;
    end

    assign bus.m0_grnt_ = grant_n[0];
    assign bus.m1_grnt_ = grant_n[1];
    assign bus.m2_grnt_ = grant_n[2];
    assign bus.m3_grnt_ = grant_n[3];
    assign bus.owner    = owner_q;
    assign bus.turn     = (state == TURN);
endmodule
